booth_mul_seq: RTL and testbench

//  Sequential signed multiplier, the inverse operation of the ALU's combinational divider.
//  It produces the full 2*WIDTH-bit two's-complement product of M*Q into HI/LO result words.
//  The block uses radix-4 Booth recoding, retiring one multiplier digit pair per clock.
//  It sits beside the divider in the ALU and is driven by the control unit through a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 18 +
 rtl/booth_mul_seq_if.sv | 21 ++
 rtl/booth_recoder.sv | 20 ++
 rtl/booth_mul_seq.sv | 112 +++++++++++
 tb/tb_booth_mul_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encodings and Booth partial-product select codes.
package alu_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef enum logic [2:0] {
    BS_ZERO = 3'd0,
    BS_P1   = 3'd1,
    BS_P2   = 3'd2,
    BS_M1   = 3'd3,
    BS_M2   = 3'd4
  } booth_sel_e;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Control-unit to multiplier bundle: operand request, HI/LO result and status.
interface booth_mul_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  // start is a request taken only while busy is low (IDLE); a request seen while
  // busy is dropped, not queued. done pulses for one cycle when hi/lo become valid,
  // and hi/lo then hold that product until the next done.
  logic             start;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  mul_state_e       state;

  modport master (output start, M, Q, input hi, lo, busy, done, state);
  modport slave  (input start, M, Q, output hi, lo, busy, done, state);
endinterface

// File: rtl/booth_recoder.sv
// Radix-4 Booth digit recoder: {Q[1],Q[0],q_1} to a partial-product select code.
module booth_recoder
  import alu_pkg::*;
(
  input  logic [2:0] digit_i,
  output booth_sel_e sel_o
);

  always_comb begin
    sel_o = BS_ZERO;
    case (digit_i)
      3'b001, 3'b010: sel_o = BS_P1;
      3'b011:         sel_o = BS_P2;
      3'b100:         sel_o = BS_M2;
      3'b101, 3'b110: sel_o = BS_M1;
      default:        sel_o = BS_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier: one digit pair per clock, 2*WIDTH-bit product on HI/LO.
module booth_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic clear,
  booth_mul_seq_if.slave bus
);

  localparam int            CW    = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] STEPS = CW'(WIDTH / 2);
  localparam logic [WIDTH+1:0] ONE = {{(WIDTH + 1){1'b0}}, 1'b1};

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  booth_sel_e       sel;
  logic [WIDTH+1:0] m_ext, pp, sum;

  booth_recoder u_recoder (
    .digit_i ({q_q[1:0], q1_q}),
    .sel_o   (sel)
  );

  // Two guard bits on the accumulator keep +/-2M and the most-negative operand exact.
  always_comb begin
    m_ext = {{2{m_q[WIDTH-1]}}, m_q};
    pp    = '0;
    case (sel)
      BS_P1:   pp = m_ext;
      BS_P2:   pp = m_ext << 1;
      BS_M1:   pp = ~m_ext + ONE;
      BS_M2:   pp = ~(m_ext << 1) + ONE;
      default: pp = '0;
    endcase
    sum = acc_q + pp;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MUL_IDLE: begin
        if (bus.start) begin
          state_d = MUL_CALC;
          m_d     = bus.M;
          q_d     = bus.Q;
          acc_d   = '0;
          q1_d    = 1'b0;
          count_d = '0;
        end
      end
      MUL_CALC: begin
        if (count_q == STEPS) begin
          state_d = MUL_DONE;
          hi_d    = acc_q[WIDTH-1:0];
          lo_d    = q_q;
        end else begin
          acc_d   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
          q_d     = {sum[1:0], q_q[WIDTH-1:2]};
          q1_d    = q_q[1];
          count_d = count_q + 1'b1;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= MUL_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q != MUL_IDLE);
  assign bus.done  = (state_q == MUL_DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed corner cases plus random signed pairs against a 64-bit multiply.
module tb_booth_mul_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  booth_mul_seq_if #(.WIDTH(W)) bus ();

  booth_mul_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [2*W-1:0] exp_q[$];
  int             start_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done must match the oldest pending request.
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    if (!clear) begin
      if (bus.done) begin
        check("done_prev_cycle", prev_done, 0);
        check("done_has_request", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [2*W-1:0] e;
          int s;
          e = exp_q.pop_front();
          s = start_q.pop_front();
          check("product", {bus.hi, bus.lo}, e);
          check("latency", cyc - s, 17);
          check("busy_cycles", busy_run, 17);
        end
      end
      busy_run  = bus.busy ? busy_run + 1 : 0;
      prev_done = bus.done;
    end else begin
      busy_run  = 0;
      prev_done = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    int t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (bus.busy) check("idle_timeout", bus.busy, 0);
    bus.start = 1'b1;
    bus.M     = m;
    bus.Q     = q;
    exp_q.push_back(ref_mul(m, q));
    start_q.push_back(cyc + 1);
    @(negedge clock);
    bus.start = 1'b0;
    bus.M     = $urandom;
    bus.Q     = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus.done) check("done_timeout", bus.done, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.M     = '0;
    bus.Q     = '0;

    repeat (2) @(negedge clock);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_hilo", {bus.hi, bus.lo}, 0);
    check("reset_state", bus.state, MUL_IDLE);
    clear = 1'b0;
    @(negedge clock);

    start_op(32'd7, 32'd6);
    start_op(32'hFFFF_FFF9, 32'd6);
    start_op(32'd6, 32'hFFFF_FFF9);
    start_op(32'h8000_0000, 32'h8000_0000);
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    start_op(32'h0000_0000, 32'hDEAD_BEEF);

    // Extra requests during CALC and during DONE must be dropped.
    start_op(32'd1234, 32'hFFFF_F000);
    repeat (2) @(negedge clock);
    bus.start = 1'b1;
    bus.M     = 32'd99;
    bus.Q     = 32'd77;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done();
    bus.start = 1'b1;
    bus.M     = 32'd55;
    bus.Q     = 32'd33;
    @(negedge clock);
    start_op(32'd123, 32'hFFFF_FFD3);
    wait_done();
    @(negedge clock);

    // Abort mid-operation with an asynchronous clear.
    start_op(32'h1234_5678, 32'h0FED_CBA9);
    repeat (8) @(posedge clock);
    #2 clear = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hilo", {bus.hi, bus.lo}, 0);
    void'(exp_q.pop_back());
    void'(start_q.pop_back());
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    start_op(32'hFFFF_FF85, 32'd1000);

    for (int i = 0; i < 1500; i++) begin
      start_op(pick(), pick());
    end

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        @(negedge clock);
        t++;
      end
      check("drain_pending", exp_q.size(), 0);
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
